// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment P2S scheduler.
//   state_t : scheduler FSM states
//   SRC_*   : codes reported on cur_src (who supplied the word on p2s_num)
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_0    = 2'd1;
    localparam logic [1:0] SRC_1    = 2'd2;
    localparam logic [1:0] SRC_REF  = 2'd3;

endpackage

// File: rtl/seg_p2s_sched_rr_arb2.sv
// Two-input round-robin arbiter.
//   clk, CR    : clock, synchronous active-low reset
//   req[1:0]   : request vector
//   advance    : a grant is really being issued this cycle; only then does
//                the priority pointer move
//   gnt_onehot : combinational one-hot winner (all zero when no request)
module rr_arb2 (
    input  logic       clk,
    input  logic       CR,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt_onehot
);

    // 1 = requester 1 won last, so requester 0 is favoured next.
    logic last_reg;

    always_ff @(posedge clk) begin
        if (!CR) begin
            last_reg <= 1'b1;
        end else if (advance && (gnt_onehot != 2'b00)) begin
            last_reg <= gnt_onehot[1];
        end
    end

    always_comb begin
        gnt_onehot = 2'b00;
        unique case (req)
            2'b01:   gnt_onehot = 2'b01;
            2'b10:   gnt_onehot = 2'b10;
            2'b11:   gnt_onehot = last_reg ? 2'b01 : 2'b10;
            default: gnt_onehot = 2'b00;
        endcase
    end

endmodule

// File: rtl/seg_p2s_sched.sv
// Scheduler for the shared 7-segment P2S driver.
//   clk, CR            : clock, synchronous active-low reset
//   req0/num0,req1/num1: requesters; gnt0/gnt1 pulse in the cycle the word is taken
//   p2s_busy           : driver shifting in progress
//   p2s_start          : start pulse to the driver (START_LEN cycles)
//   p2s_num            : word presented to the driver
//   cur_src            : origin of p2s_num (none / req0 / req1 / refresh)
//   to_err             : sticky, driver never raised busy after a start
module seg_p2s_sched
    import seg_pkg::*;
#(
    parameter int unsigned START_LEN   = 2,
    parameter int unsigned BUSY_TO     = 16,
    parameter int unsigned REFRESH_CYC = 1000000
) (
    input  logic        clk,
    input  logic        CR,
    input  logic        req0,
    input  logic [31:0] num0,
    input  logic        req1,
    input  logic [31:0] num1,
    output logic        gnt0,
    output logic        gnt1,
    input  logic        p2s_busy,
    output logic        p2s_start,
    output logic [31:0] p2s_num,
    output logic [1:0]  cur_src,
    output logic        to_err
);

    localparam int LCNT_W = $clog2(START_LEN + 1);
    localparam int TCNT_W = $clog2(BUSY_TO + 1);
    localparam logic [31:0] REFRESH_LAST = (REFRESH_CYC == 0) ? 32'd0 : REFRESH_CYC - 1;
    localparam logic [LCNT_W-1:0] LAUNCH_LAST = LCNT_W'(START_LEN - 1);
    localparam logic [TCNT_W-1:0] TMO_LAST    = TCNT_W'(BUSY_TO - 1);

    state_t             state_reg, state_next;
    logic [LCNT_W-1:0]  launch_cnt_reg;
    logic [TCNT_W-1:0]  tmo_cnt_reg;
    logic [31:0]        idle_cnt_reg;
    logic               busy_seen_reg;
    logic [31:0]        p2s_num_reg;
    logic [1:0]         cur_src_reg;
    logic               to_err_reg;

    logic [1:0]         arb_gnt;
    logic               any_req;
    logic               do_grant;
    logic               refresh_hit;
    logic               set_to_err;

    assign any_req  = req0 | req1;
    // Grants are suppressed during reset so that the reset cycle shows
    // clean outputs even while a requester keeps its request high.
    assign do_grant = CR && (state_reg == ST_IDLE) && !p2s_busy && any_req;

    // Refresh only when nobody is asking (a request always wins), the
    // driver is free and something has been shown before. ">=" keeps the
    // refresh pending if a foreign transfer straddles the due cycle.
    assign refresh_hit = (REFRESH_CYC != 0) && (state_reg == ST_IDLE) && !any_req &&
                         !p2s_busy && (cur_src_reg != SRC_NONE) &&
                         (idle_cnt_reg >= REFRESH_LAST);

    rr_arb2 u_arb (
        .clk        (clk),
        .CR         (CR),
        .req        ({req1, req0}),
        .advance    (do_grant),
        .gnt_onehot (arb_gnt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!CR) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        set_to_err = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (do_grant || refresh_hit) begin
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (launch_cnt_reg == LAUNCH_LAST) begin
                    // A busy rise seen while still pulsing start skips WAIT_BUSY.
                    state_next = (busy_seen_reg || p2s_busy) ? ST_WAIT_DONE : ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (p2s_busy) begin
                    state_next = ST_WAIT_DONE;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    state_next = ST_IDLE;
                    set_to_err = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!p2s_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        gnt0      = do_grant & arb_gnt[0];
        gnt1      = do_grant & arb_gnt[1];
        p2s_start = (state_reg == ST_LAUNCH);
        p2s_num   = p2s_num_reg;
        cur_src   = cur_src_reg;
        to_err    = to_err_reg;
    end

    // Per-state counters, each cleared whenever its state is (re)entered.
    always_ff @(posedge clk) begin
        if (!CR) begin
            launch_cnt_reg <= '0;
            tmo_cnt_reg    <= '0;
            idle_cnt_reg   <= '0;
            busy_seen_reg  <= 1'b0;
        end else begin
            if ((state_reg == ST_LAUNCH) && (state_next == ST_LAUNCH)) begin
                launch_cnt_reg <= launch_cnt_reg + 1'b1;
                busy_seen_reg  <= busy_seen_reg | p2s_busy;
            end else begin
                launch_cnt_reg <= '0;
                busy_seen_reg  <= 1'b0;
            end

            if ((state_reg == ST_WAIT_BUSY) && (state_next == ST_WAIT_BUSY)) begin
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end else begin
                tmo_cnt_reg <= '0;
            end

            if ((state_reg == ST_IDLE) && (state_next == ST_IDLE) && !any_req) begin
                if (idle_cnt_reg != 32'hFFFF_FFFF) begin
                    idle_cnt_reg <= idle_cnt_reg + 1'b1;
                end
            end else begin
                idle_cnt_reg <= '0;
            end
        end
    end

    // Word/source latch and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!CR) begin
            p2s_num_reg <= '0;
            cur_src_reg <= SRC_NONE;
            to_err_reg  <= 1'b0;
        end else begin
            if (do_grant) begin
                p2s_num_reg <= arb_gnt[0] ? num0 : num1;
                cur_src_reg <= arb_gnt[0] ? SRC_0 : SRC_1;
            end else if (refresh_hit) begin
                cur_src_reg <= SRC_REF;
            end
            if (set_to_err) begin
                to_err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_p2s_sched.sv
// Directed bench for seg_p2s_sched (START_LEN=2, BUSY_TO=16, REFRESH_CYC=100).
// A small driver model raises p2s_busy the cycle after a start rising edge
// and holds it for drv_len cycles when drv_en=1.
module tb_seg_p2s_sched;

    logic        clk = 1'b0;
    logic        CR;
    logic        req0, req1;
    logic [31:0] num0, num1;
    logic        gnt0, gnt1;
    logic        p2s_busy;
    logic        p2s_start;
    logic [31:0] p2s_num;
    logic [1:0]  cur_src;
    logic        to_err;

    int n_vec = 0;
    int n_bad = 0;

    logic        drv_en = 1'b1;
    int          drv_len = 64;
    int          busy_cnt = 0;
    logic        start_d = 1'b0;
    int          start_rises = 0;

    always #5 clk = ~clk;

    seg_p2s_sched #(
        .START_LEN   (2),
        .BUSY_TO     (16),
        .REFRESH_CYC (100)
    ) dut (
        .clk       (clk),
        .CR        (CR),
        .req0      (req0),
        .num0      (num0),
        .req1      (req1),
        .num1      (num1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .p2s_busy  (p2s_busy),
        .p2s_start (p2s_start),
        .p2s_num   (p2s_num),
        .cur_src   (cur_src),
        .to_err    (to_err)
    );

    // Driver model
    assign p2s_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        start_d <= p2s_start;
        if (p2s_start && !start_d) start_rises <= start_rises + 1;
        if (!CR) busy_cnt <= 0;
        else if (drv_en && p2s_start && !start_d) busy_cnt <= drv_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        CR = 1'b0; req0 = 1'b0; req1 = 1'b0; num0 = '0; num1 = '0;
        repeat (3) tick();
        CR = 1'b1;
    endtask

    task automatic test_reset();
        CR = 1'b0; req0 = 1'b0; req1 = 1'b0; num0 = '0; num1 = '0;
        repeat (3) tick();
        #1;
        n_vec++; if ({gnt1, gnt0} !== 2'b00) begin n_bad++; $display("FAIL rst_gnt got=%b exp=00", {gnt1, gnt0}); end
        n_vec++; if (p2s_start !== 1'b0) begin n_bad++; $display("FAIL rst_start got=%b exp=0", p2s_start); end
        n_vec++; if (p2s_num !== 32'h0) begin n_bad++; $display("FAIL rst_num got=%h exp=0", p2s_num); end
        n_vec++; if (cur_src !== 2'd0) begin n_bad++; $display("FAIL rst_src got=%0d exp=0", cur_src); end
        n_vec++; if (to_err !== 1'b0) begin n_bad++; $display("FAIL rst_to_err got=%b exp=0", to_err); end
        CR = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int k;
        do_reset();
        drv_en = 1'b1; drv_len = 64;
        req0 = 1'b1; num0 = 32'h1010_5809;
        #1;
        n_vec++; if (gnt0 !== 1'b1) begin n_bad++; $display("FAIL basic_gnt0 got=%b exp=1", gnt0); end
        tick(); req0 = 1'b0; #1;
        n_vec++; if (p2s_start !== 1'b1) begin n_bad++; $display("FAIL basic_start1 got=%b exp=1", p2s_start); end
        n_vec++; if (p2s_num !== 32'h1010_5809) begin n_bad++; $display("FAIL basic_num got=%h exp=10105809", p2s_num); end
        n_vec++; if (cur_src !== 2'd1) begin n_bad++; $display("FAIL basic_src got=%0d exp=1", cur_src); end
        n_vec++; if (gnt0 !== 1'b0) begin n_bad++; $display("FAIL basic_gnt_once got=%b exp=0", gnt0); end
        tick(); #1;
        n_vec++; if (p2s_start !== 1'b1) begin n_bad++; $display("FAIL basic_start2 got=%b exp=1", p2s_start); end
        tick(); #1;
        n_vec++; if (p2s_start !== 1'b0) begin n_bad++; $display("FAIL basic_start3 got=%b exp=0", p2s_start); end
        // Busy window: 64 cycles, beginning the cycle after the start edge.
        k = 0;
        while (p2s_busy && k < 200) begin tick(); #1; k++; end
        n_vec++; if (k !== 63) begin n_bad++; $display("FAIL basic_busy_len got=%0d exp=63", k); end
        // First busy-low cycle is still WAIT_DONE; the grant comes one cycle later.
        req0 = 1'b1; num0 = 32'h0000_00A5; #1;
        n_vec++; if (gnt0 !== 1'b0) begin n_bad++; $display("FAIL basic_gap got=%b exp=0", gnt0); end
        tick(); #1;
        n_vec++; if (gnt0 !== 1'b1) begin n_bad++; $display("FAIL basic_regrant got=%b exp=1", gnt0); end
        tick(); req0 = 1'b0;
        repeat (70) tick();
        $display("test_basic done");
    endtask

    task automatic test_round_robin();
        int k;
        int s0;
        logic exp0;
        do_reset();
        drv_en = 1'b1; drv_len = 5;
        s0 = start_rises;
        req0 = 1'b1; num0 = 32'h1111_0000;
        req1 = 1'b1; num1 = 32'hDEAD_BEEF;
        #1;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            while (!(gnt0 || gnt1) && k < 200) begin tick(); #1; k++; end
            exp0 = (i % 2 == 0);
            n_vec++;
            if (k >= 200 || {gnt1, gnt0} !== {~exp0, exp0}) begin
                n_bad++; $display("FAIL rr_order%0d got=%b exp=%b", i, {gnt1, gnt0}, {~exp0, exp0});
            end
            n_vec++; if (p2s_busy !== 1'b0) begin n_bad++; $display("FAIL rr_overlap%0d got=%b exp=0", i, p2s_busy); end
            n_vec++; if (start_rises - s0 !== i) begin n_bad++; $display("FAIL rr_starts%0d got=%0d exp=%0d", i, start_rises - s0, i); end
            tick(); #1;
            n_vec++;
            if (p2s_num !== (exp0 ? 32'h1111_0000 : 32'hDEAD_BEEF)) begin
                n_bad++; $display("FAIL rr_num%0d got=%h exp=%h", i, p2s_num, exp0 ? 32'h1111_0000 : 32'hDEAD_BEEF);
            end
            $display("rr grant %0d to req%0d", i, exp0 ? 0 : 1);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_timeout();
        do_reset();
        drv_en = 1'b0;
        req1 = 1'b1; num1 = 32'h0BAD_0BAD; #1;
        n_vec++; if (gnt1 !== 1'b1) begin n_bad++; $display("FAIL to_gnt1 got=%b exp=1", gnt1); end
        tick(); req1 = 1'b0;
        repeat (17) tick(); #1;
        n_vec++; if (to_err !== 1'b0) begin n_bad++; $display("FAIL to_early got=%b exp=0", to_err); end
        tick(); #1;
        n_vec++; if (to_err !== 1'b1) begin n_bad++; $display("FAIL to_set got=%b exp=1", to_err); end
        req0 = 1'b1; num0 = 32'h5555_AAAA; #1;
        n_vec++; if (gnt0 !== 1'b1) begin n_bad++; $display("FAIL to_regrant got=%b exp=1", gnt0); end
        tick(); req0 = 1'b0;
        repeat (30) tick(); #1;
        n_vec++; if (to_err !== 1'b1) begin n_bad++; $display("FAIL to_sticky got=%b exp=1", to_err); end
        drv_en = 1'b1;
        $display("test_timeout done");
    endtask

    task automatic test_refresh();
        int s0;
        do_reset();
        drv_en = 1'b1; drv_len = 5;
        s0 = start_rises;
        repeat (150) tick(); #1;
        n_vec++; if (start_rises - s0 !== 0) begin n_bad++; $display("FAIL ref_none got=%0d exp=0", start_rises - s0); end
        req0 = 1'b1; num0 = 32'hCAFE_0123; #1;
        n_vec++; if (gnt0 !== 1'b1) begin n_bad++; $display("FAIL ref_gnt got=%b exp=1", gnt0); end
        tick(); req0 = 1'b0;
        repeat (106) tick(); #1;
        n_vec++; if (p2s_start !== 1'b0) begin n_bad++; $display("FAIL ref_early got=%b exp=0", p2s_start); end
        tick(); #1;
        n_vec++; if (p2s_start !== 1'b1) begin n_bad++; $display("FAIL ref_start got=%b exp=1", p2s_start); end
        n_vec++; if ({gnt1, gnt0} !== 2'b00) begin n_bad++; $display("FAIL ref_nognt got=%b exp=00", {gnt1, gnt0}); end
        n_vec++; if (cur_src !== 2'd3) begin n_bad++; $display("FAIL ref_src got=%0d exp=3", cur_src); end
        n_vec++; if (p2s_num !== 32'hCAFE_0123) begin n_bad++; $display("FAIL ref_num got=%h exp=cafe0123", p2s_num); end
        // Second refresh would be decided in this cycle; a request must win.
        repeat (106) tick();
        req1 = 1'b1; num1 = 32'h7777_1234; #1;
        n_vec++; if (gnt1 !== 1'b1) begin n_bad++; $display("FAIL ref_reqwin got=%b exp=1", gnt1); end
        tick(); req1 = 1'b0; #1;
        n_vec++; if (cur_src !== 2'd2) begin n_bad++; $display("FAIL ref_skip_src got=%0d exp=2", cur_src); end
        n_vec++; if (p2s_num !== 32'h7777_1234) begin n_bad++; $display("FAIL ref_skip_num got=%h exp=77771234", p2s_num); end
        n_vec++; if (p2s_start !== 1'b1) begin n_bad++; $display("FAIL ref_skip_start got=%b exp=1", p2s_start); end
        repeat (20) tick();
        $display("test_refresh done");
    endtask

    task automatic test_midreset();
        do_reset();
        drv_en = 1'b1; drv_len = 64;
        req1 = 1'b1; num1 = 32'h1234_5678; #1;
        n_vec++; if (gnt1 !== 1'b1) begin n_bad++; $display("FAIL mr_gnt got=%b exp=1", gnt1); end
        repeat (10) tick();
        CR = 1'b0;
        tick(); #1;
        n_vec++; if ({gnt1, gnt0} !== 2'b00) begin n_bad++; $display("FAIL mr_gnt_rst got=%b exp=00", {gnt1, gnt0}); end
        n_vec++; if (p2s_start !== 1'b0) begin n_bad++; $display("FAIL mr_start got=%b exp=0", p2s_start); end
        n_vec++; if (p2s_num !== 32'h0) begin n_bad++; $display("FAIL mr_num got=%h exp=0", p2s_num); end
        n_vec++; if (cur_src !== 2'd0) begin n_bad++; $display("FAIL mr_src got=%0d exp=0", cur_src); end
        CR = 1'b1; #1;
        n_vec++; if (gnt1 !== 1'b1) begin n_bad++; $display("FAIL mr_regrant got=%b exp=1", gnt1); end
        tick(); req1 = 1'b0; #1;
        n_vec++; if (p2s_num !== 32'h1234_5678) begin n_bad++; $display("FAIL mr_num2 got=%h exp=12345678", p2s_num); end
        n_vec++; if (cur_src !== 2'd2) begin n_bad++; $display("FAIL mr_src2 got=%0d exp=2", cur_src); end
        n_vec++; if (p2s_start !== 1'b1) begin n_bad++; $display("FAIL mr_start2 got=%b exp=1", p2s_start); end
        $display("test_midreset done");
    endtask

    initial begin
        CR = 1'b0; req0 = 1'b0; req1 = 1'b0; num0 = '0; num1 = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_timeout();
        test_refresh();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
